interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 62 ++++++
 tb/tb_interrupt_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: two-source interrupt controller with synchronized edge capture,
// non-maskable INT0 priority over maskable INT1, and single-level service with IE save/restore.
module interrupt_controller #(
    parameter logic [15:0] VEC0 = 16'h0004,
    parameter logic [15:0] VEC1 = 16'h0008
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        INT0,
    input  logic        INT1,
    input  logic        EI,
    input  logic        DI,
    input  logic        RETI,
    input  logic        INT_ACK,
    output logic        INT_REQ,
    output logic [15:0] INT_VECTOR,
    output logic        INT_ACTIVE,
    output logic        INT_SRC,
    output logic        IE
);
    typedef enum logic {IDLE, SERVICE} state_t;
    state_t state;
    logic [1:0] sync1, sync2, prev, pend, rise, clr;
    logic ie_saved, take;
    assign rise = sync2 & ~prev;
    assign INT_REQ = state == IDLE && (pend[0] || (pend[1] && IE));
    assign INT_VECTOR = pend[0] ? VEC0 : (pend[1] && IE) ? VEC1 : 16'h0000;
    assign INT_ACTIVE = state == SERVICE;
    assign take = INT_ACK && INT_REQ;
    // A fresh edge on the acknowledged source re-sets its pending bit in the same cycle
    assign clr = take ? (pend[0] ? 2'b01 : 2'b10) : 2'b00;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            sync1    <= 2'b00;
            sync2    <= 2'b00;
            prev     <= 2'b00;
            pend     <= 2'b00;
            IE       <= 1'b0;
            ie_saved <= 1'b0;
            INT_SRC  <= 1'b0;
        end else begin
            sync1 <= {INT1, INT0};
            sync2 <= sync1;
            prev  <= sync2;
            pend  <= (pend & ~clr) | rise;
            if (take) begin
                state    <= SERVICE;
                INT_SRC  <= ~pend[0];
                ie_saved <= IE;
                IE       <= 1'b0;
            end else if (RETI && state == SERVICE) begin
                state <= IDLE;
                IE    <= ie_saved;
            end else if (DI) begin
                IE <= 1'b0;
            end else if (EI) begin
                IE <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: scoreboard bench; each step queues the outputs expected after
// the next rising edge and a negedge monitor pops and compares them.
module tb_interrupt_controller;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1, INT0 = 1'b0, INT1 = 1'b0;
    logic        EI = 1'b0, DI = 1'b0, RETI = 1'b0, INT_ACK = 1'b0;
    logic        INT_REQ, INT_ACTIVE, INT_SRC, IE;
    logic [15:0] INT_VECTOR;

    typedef struct {
        int          due;
        string       tag;
        logic [19:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    interrupt_controller dut (
        .CLK(CLK), .RESET(RESET), .INT0(INT0), .INT1(INT1), .EI(EI), .DI(DI),
        .RETI(RETI), .INT_ACK(INT_ACK), .INT_REQ(INT_REQ), .INT_VECTOR(INT_VECTOR),
        .INT_ACTIVE(INT_ACTIVE), .INT_SRC(INT_SRC), .IE(IE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle <= cycle + 1;

    task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got req/vec/act/src/ie=%h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] o(input bit req, input logic [15:0] vec,
                                      input bit act, input bit src, input bit ie);
        return {req, vec, act, src, ie};
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cycle) begin
            e = sb.pop_front();
            check_eq(e.tag, {INT_REQ, INT_VECTOR, INT_ACTIVE, INT_SRC, IE}, e.exp);
        end
    end

    task automatic step(input string tag, input bit rst, input bit ack, input bit reti,
                        input bit ei, input bit di, input logic [19:0] exp);
        RESET = rst; INT_ACK = ack; RETI = reti; EI = ei; DI = di;
        sb.push_back('{cycle + 1, tag, exp});
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        RESET = 0; INT_ACK = 0; RETI = 0; EI = 0; DI = 0;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge CLK);
        step("rst",          1, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        step("rst_hold",     1, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        step("ack_no_req",   0, 1, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        // INT0 with IE=0
        INT0 = 1;
        step("i0_k",         0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        step("i0_k1",        0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        step("i0_req",       0, 0, 0, 0, 0, o(1, 16'h4, 0, 0, 0));
        step("i0_ack",       0, 1, 0, 0, 0, o(0, 16'h0, 1, 0, 0));
        step("i0_reti",      0, 0, 1, 0, 0, o(0, 16'h0, 0, 0, 0));
        idle(4);
        step("i0_held",      0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        INT0 = 0;
        idle(3);
        INT0 = 1;
        step("i0_re_k",      0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        step("i0_re_k1",     0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        step("i0_re_req",    0, 0, 0, 0, 0, o(1, 16'h4, 0, 0, 0));
        step("i0_re_ack",    0, 1, 0, 0, 0, o(0, 16'h0, 1, 0, 0));
        step("i0_re_reti",   0, 0, 1, 0, 0, o(0, 16'h0, 0, 0, 0));
        INT0 = 0;
        idle(3);
        // INT1 pulse masked until EI
        INT1 = 1;
        step("i1_pulse",     0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        INT1 = 0;
        for (int i = 0; i < 10; i++)
            step("i1_masked",  0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        step("i1_ei",        0, 0, 0, 1, 0, o(1, 16'h8, 0, 0, 1));
        step("i1_ack",       0, 1, 0, 0, 0, o(0, 16'h0, 1, 1, 0));
        step("i1_reti",      0, 0, 1, 0, 0, o(0, 16'h0, 0, 1, 1));
        // Simultaneous edges, INT0 first
        INT0 = 1; INT1 = 1;
        step("both_k",       0, 0, 0, 0, 0, o(0, 16'h0, 0, 1, 1));
        step("both_k1",      0, 0, 0, 0, 0, o(0, 16'h0, 0, 1, 1));
        INT0 = 0; INT1 = 0;
        step("both_req0",    0, 0, 0, 0, 0, o(1, 16'h4, 0, 1, 1));
        step("both_ack0",    0, 1, 0, 0, 0, o(0, 16'h0, 1, 0, 0));
        step("both_reti0",   0, 0, 1, 0, 0, o(1, 16'h8, 0, 0, 1));
        step("both_ack1",    0, 1, 0, 0, 0, o(0, 16'h0, 1, 1, 0));
        step("svc_ei",       0, 0, 0, 1, 0, o(0, 16'h0, 1, 1, 1));
        step("reti_vs_di",   0, 0, 1, 0, 1, o(0, 16'h0, 0, 1, 1));
        // New INT0 edge coinciding with its ack, with DI in the same cycle
        INT0 = 1;
        step("coin_k",       0, 0, 0, 0, 0, o(0, 16'h0, 0, 1, 1));
        INT0 = 0;
        step("coin_k1",      0, 0, 0, 0, 0, o(0, 16'h0, 0, 1, 1));
        INT0 = 1;
        step("coin_req",     0, 0, 0, 0, 0, o(1, 16'h4, 0, 1, 1));
        INT0 = 0;
        step("coin_k3",      0, 0, 0, 0, 0, o(1, 16'h4, 0, 1, 1));
        step("coin_ack_di",  0, 1, 0, 0, 1, o(0, 16'h4, 1, 0, 0));
        step("coin_reti",    0, 0, 1, 0, 0, o(1, 16'h4, 0, 0, 1));
        step("coin_ack2",    0, 1, 0, 0, 0, o(0, 16'h0, 1, 0, 0));
        step("coin_reti2",   0, 0, 1, 0, 0, o(0, 16'h0, 0, 0, 1));
        // EI+DI, RETI in IDLE, reset mid-service
        step("ei_di",        0, 0, 0, 1, 1, o(0, 16'h0, 0, 0, 0));
        step("reti_idle",    0, 0, 1, 0, 0, o(0, 16'h0, 0, 0, 0));
        INT0 = 1;
        step("rs_k",         0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        step("rs_k1",        0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        step("rs_req",       0, 0, 0, 0, 0, o(1, 16'h4, 0, 0, 0));
        INT0 = 0;
        step("rs_ack",       0, 1, 0, 0, 0, o(0, 16'h0, 1, 0, 0));
        step("rst_in_svc",   1, 0, 0, 1, 0, o(0, 16'h0, 0, 0, 0));
        step("reti_post_rst",0, 0, 1, 0, 0, o(0, 16'h0, 0, 0, 0));
        idle(3);
        step("quiet",        0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0));
        idle(2);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
